// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: resolves load-use, multi-cycle memory and ID-branch hazards
// by driving pipeline-register enables, bubbles and flushes; adds a memory watchdog.
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RS,
  input  logic [4:0]       IF_ID_RT,
  input  logic             ID_UsesRT,
  input  logic [4:0]       ID_EX_RT,
  input  logic             ID_EX_MemRead,
  input  logic             Branch_Taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Pipe_Hold,
  output logic             MEM_WB_Bubble,
  output logic             Mem_Error,
  output logic [CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } fsm_e;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExBubble;
    logic pipeHold;
    logic memWbBubble;
  } ctrl_t;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fsm_e             state, stateNext;
  logic [7:0]       waitCnt, waitCntNext;
  logic             pendFlush;
  logic             memErr;
  logic [CNT_W-1:0] stallCnt;

  logic  memBusy, loadUse, frozen, timeoutHit;
  ctrl_t ctrl;

  always_comb begin
    memBusy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~Mem_Ready;
    loadUse = ID_EX_MemRead & (ID_EX_RT != 5'd0) &
              ((ID_EX_RT == IF_ID_RS) | (ID_UsesRT & (ID_EX_RT == IF_ID_RT)));
    frozen  = (state == ERROR) | memBusy;
    timeoutHit = (state == MEM_WAIT) & memBusy & (waitCnt == TIMEOUT);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= 8'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // next-state
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      RUN: begin
        if (memBusy) begin
          stateNext   = MEM_WAIT;
          waitCntNext = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!memBusy) begin
          stateNext   = RUN;
          waitCntNext = 8'd0;
        end else if (timeoutHit) begin
          stateNext   = ERROR;
        end else begin
          waitCntNext = waitCnt + 8'd1;
        end
      end
      ERROR: ;
      default: begin
        stateNext   = RUN;
        waitCntNext = 8'd0;
      end
    endcase
  end

  // outputs; a branch seen during a load-use stall has stale operands and is dropped
  always_comb begin
    ctrl           = '0;
    ctrl.pcWrite   = 1'b1;
    ctrl.ifIdWrite = 1'b1;
    if (reset) begin
      ctrl.pcWrite   = 1'b1;
    end else if (frozen) begin
      ctrl.pcWrite     = 1'b0;
      ctrl.ifIdWrite   = 1'b0;
      ctrl.pipeHold    = 1'b1;
      ctrl.memWbBubble = 1'b1;
    end else if (loadUse) begin
      ctrl.pcWrite    = 1'b0;
      ctrl.ifIdWrite  = 1'b0;
      ctrl.idExBubble = 1'b1;
    end else if (Branch_Taken | pendFlush) begin
      ctrl.ifIdFlush = 1'b1;
    end
  end

  // a branch resolved while frozen is remembered and flushed on the first free cycle
  always_ff @(posedge clk) begin
    if (reset)
      pendFlush <= 1'b0;
    else if (frozen & Branch_Taken)
      pendFlush <= 1'b1;
    else if (!frozen & !loadUse & (Branch_Taken | pendFlush))
      pendFlush <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      memErr <= 1'b0;
    else if (timeoutHit)
      memErr <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stallCnt <= '0;
    else if (!ctrl.pcWrite && (stallCnt != {CNT_W{1'b1}}))
      stallCnt <= stallCnt + CNT_ONE;
  end

  assign PC_Write      = ctrl.pcWrite;
  assign IF_ID_Write   = ctrl.ifIdWrite;
  assign IF_ID_Flush   = ctrl.ifIdFlush;
  assign ID_EX_Bubble  = ctrl.idExBubble;
  assign Pipe_Hold     = ctrl.pipeHold;
  assign MEM_WB_Bubble = ctrl.memWbBubble;
  assign Mem_Error     = memErr;
  assign Stall_Count   = stallCnt;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Producer-side partner to the EX-stage forwarding logic. It detects the hazards that forwarding cannot resolve: load-use dependences, multi-cycle data-memory accesses and ID-stage taken branches. It drives the pipeline-register write-enables, bubbles and flushes for the 5-stage MIPS pipeline. It also keeps a memory-timeout watchdog and a saturating stall-cycle counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before the error trap (1..255)
CNT_W, 16, width of Stall_Count

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
IF_ID_RS  in  5  rs of instruction in ID
IF_ID_RT  in  5  rt of instruction in ID
ID_UsesRT  in  1  ID instruction reads rt as a source
ID_EX_RT  in  5  destination of instruction in EX
ID_EX_MemRead  in  1  instruction in EX is a load
Branch_Taken  in  1  branch resolved taken in ID this cycle
EX_MEM_MemRead  in  1  load in MEM stage
EX_MEM_MemWrite  in  1  store in MEM stage
Mem_Ready  in  1  data memory completes access this cycle
PC_Write  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  zero IF/ID at next edge
ID_EX_Bubble  out  1  load NOP into ID/EX at next edge
Pipe_Hold  out  1  hold ID/EX and EX/MEM contents
MEM_WB_Bubble  out  1  load NOP into MEM/WB at next edge
Mem_Error  out  1  sticky memory-timeout flag
Stall_Count  out  CNT_W  saturating count of cycles with PC_Write=0

Behaviour:
- Registered state: fsm {RUN, MEM_WAIT, ERROR}, wait_cnt[7:0], pend_flush, Stall_Count, Mem_Error. All outputs are combinational from the registered state and the current inputs.
- Reset (sampled at posedge clk while reset=1): fsm=RUN, wait_cnt=0, pend_flush=0, Stall_Count=0, Mem_Error=0.
- During a reset cycle, outputs are forced to: PC_Write=1, IF_ID_Write=1, all flush/bubble/hold=0.
- Reset mid-MEM_WAIT or in ERROR aborts the state immediately.
- mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~Mem_Ready.
- load_use = ID_EX_MemRead & (ID_EX_RT!=0) & ((ID_EX_RT==IF_ID_RS) | (ID_UsesRT & (ID_EX_RT==IF_ID_RT))).
- Priority, highest first: ERROR > mem freeze > load-use > branch flush.
- Freeze (fsm==ERROR, or mem_busy in RUN/MEM_WAIT):
  - PC_Write=0, IF_ID_Write=0, Pipe_Hold=1, MEM_WB_Bubble=1.
  - ID_EX_Bubble=0, IF_ID_Flush=0.
- Load-use (no freeze, load_use=1):
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Branch_Taken is ignored this cycle because its operands are stale. The branch re-resolves next cycle.
- Branch (no freeze, no load_use, Branch_Taken|pend_flush):
  - IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1.
  - pend_flush clears at the next edge.
- Otherwise: PC_Write=1, IF_ID_Write=1, all others 0.
- FSM transitions:
  - RUN→MEM_WAIT when mem_busy; wait_cnt←1.
  - MEM_WAIT stays while mem_busy; wait_cnt increments.
  - MEM_WAIT→RUN on the cycle Mem_Ready=1. That cycle is unfrozen, so MEM/WB captures the data; wait_cnt←0.
  - MEM_WAIT→ERROR when mem_busy and wait_cnt==MEM_TIMEOUT. Mem_Error←1 and stays set until reset.
  - ERROR is exited only by reset.
- A single-cycle access with Mem_Ready=1 in the same cycle causes no freeze and no state change.
- Branch_Taken asserted in a frozen cycle sets pend_flush. The flush is applied on the first unfrozen cycle. Multiple sets collapse into one.
- Stall_Count increments each cycle PC_Write=0 (including ERROR) and saturates at all-ones.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RT=8, IF_ID_RS=8 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 that cycle; Stall_Count 0→1. Same with ID_EX_RT=0 -> no stall.
- rt gating: ID_EX_RT=9=IF_ID_RT. With ID_UsesRT=0 -> no stall; with ID_UsesRT=1 -> one-cycle bubble.
- Memory wait: EX_MEM_MemRead=1, Mem_Ready low 3 cycles then high -> freeze exactly 3 cycles, release on the Mem_Ready cycle, fsm back to RUN, Stall_Count=3.
- Deferred branch: Branch_Taken=1 in the 2nd frozen cycle, then 0 -> IF_ID_Flush=1 only on the first unfrozen cycle, then 0.
- Timeout: MEM_TIMEOUT=4, Mem_Ready held 0 -> Mem_Error rises after the 4th wait cycle, freeze persists, Stall_Count keeps counting. Assert reset for one cycle -> all outputs return to reset values, Mem_Error=0.
- Priority/saturation: load_use, mem_busy and Branch_Taken all high -> freeze outputs only, ID_EX_Bubble=0. With CNT_W=2, a 6-cycle stall -> Stall_Count holds at 3.
